dct_block_sched: RTL

Round-robin scheduler sharing one 8x8 chroma DCT engine (Cb/Cr, serial 8-bit input, 64 samples per block) between several block requesters. It grants one requester at a time and streams exactly 64 samples into the engine. It then holds the engine's enable through its tail cycles, waits for the engine's output-enable, reports completion with the owner index, and flushes the engine before the next block. It sits between the colour-space/block-buffer stage and the chroma DCT instances.

---
 rtl/dct_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/dct_block_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/dct_sched_pkg.sv
// rtl/dct_sched_pkg.sv - shared state encoding and default timing for the chroma DCT block scheduler
package dct_sched_pkg;

  localparam int SAMPLES_PER_BLOCK = 64;
  localparam int DCT_TAIL          = 2;
  localparam int DCT_FLUSH         = 2;
  localparam int DCT_TIMEOUT       = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_TAIL,
    S_WAIT,
    S_REPORT,
    S_FLUSH
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer position
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dct_block_sched.sv
// rtl/dct_block_sched.sv - round-robin sharing of one serial 8x8 chroma DCT engine
// between block requesters: feed, tail, wait for output-enable, report, flush.
module dct_block_sched
  import dct_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int SAMPLES      = SAMPLES_PER_BLOCK,
  parameter int TAIL_CYCLES  = DCT_TAIL,
  parameter int FLUSH_CYCLES = DCT_FLUSH,
  parameter int TIMEOUT      = DCT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         s_valid,
  input  logic [NUM_REQ*8-1:0]       s_data,
  output logic [NUM_REQ-1:0]         s_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       dct_enable,
  output logic [7:0]                 dct_data,
  input  logic                       dct_output_enable,
  output logic                       dct_flush,
  output logic                       blk_done,
  output logic                       blk_timeout,
  output logic [$clog2(NUM_REQ)-1:0] blk_owner,
  output logic                       underrun,
  output logic                       busy
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (SAMPLES > TIMEOUT) ? SAMPLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  sched_state_t  state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               sel_valid;
  logic [7:0]         sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign sel_valid = s_valid[owner];
  assign sel_data  = s_data[{owner, 3'b000} +: 8];
  assign s_ready   = (state == S_FEED) ? grant : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (|req) state_nx = S_FEED;
      S_FEED:   if (cnt == CW'(SAMPLES - 1)) state_nx = S_TAIL;
      S_TAIL:   if (cnt == CW'(TAIL_CYCLES - 1)) state_nx = S_WAIT;
      S_WAIT:   if (dct_output_enable || cnt == CW'(TIMEOUT - 1)) state_nx = S_REPORT;
      S_REPORT: state_nx = S_FLUSH;
      S_FLUSH:  if (cnt == CW'(FLUSH_CYCLES - 1)) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // The engine cannot stall: a FEED cycle without valid data still counts and re-sends the held byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      ptr         <= '0;
      owner       <= '0;
      grant       <= '0;
      dct_enable  <= 1'b0;
      dct_data    <= '0;
      dct_flush   <= 1'b0;
      blk_done    <= 1'b0;
      blk_timeout <= 1'b0;
      blk_owner   <= '0;
      underrun    <= 1'b0;
    end else begin
      if (state_nx != state)    cnt <= '0;
      else if (state != S_IDLE) cnt <= cnt + CW'(1);

      dct_enable  <= (state == S_FEED) || (state == S_TAIL);
      dct_flush   <= (state_nx == S_FLUSH);
      underrun    <= (state == S_FEED) && !sel_valid;
      blk_done    <= (state == S_WAIT) && dct_output_enable;
      blk_timeout <= (state == S_WAIT) && !dct_output_enable && (cnt == CW'(TIMEOUT - 1));

      if (state == S_FEED && sel_valid) dct_data <= sel_data;

      if (state == S_IDLE && |req) begin
        grant <= arb_grant;
        owner <= arb_idx;
      end

      if (state == S_WAIT && state_nx == S_REPORT) blk_owner <= owner;

      if (state == S_REPORT) begin
        grant <= '0;
        ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
      end
    end
  end

endmodule
